// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: the FSM state
//   encoding and the framing constants of the byte stream (two length bytes,
//   four payload bytes per 32-bit instruction word).
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  // Framing of the incoming byte stream
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Derived widths used by the loader datapath
  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int BCNT_W = $clog2(BYTES_PER_WORD);

  // Loader FSM states, in the order a successful frame walks through them
  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Streams a program image into instruction memory and then releases the
//   core. Frame format on the byte stream:
//     word count N (16 bit, low byte first), 4*N payload bytes (each word
//     little-endian), one checksum byte.
//   Word k is written at BASE_ADDR+k (modulo 2^ADDR_W). Frames with
//   N > 2^ADDR_W are rejected before any write.
//
// Configuration macro:
//   IMEM_LOADER_CSUM_EN  when defined, the checksum byte must equal the
//                        modulo-256 sum of all length and payload bytes,
//                        otherwise the load ends in ERR. When undefined the
//                        checksum byte is consumed and ignored.
//
// Parameters:
//   ADDR_W     instruction-memory word-address width (depth 2^ADDR_W)
//   BASE_ADDR  word address of the first instruction written
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high reset
//   load_req    one-cycle request to restart a load from DONE or ERR
//   in_valid    a byte is present on in_data
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe (one cycle per word)
//   imem_addr   word address of the write
//   imem_wdata  instruction word being written
//   core_reset  holds the core in reset everywhere except DONE
//   start       one-cycle pulse, one cycle after DONE is entered
//   done        load completed successfully (level)
//   error       load aborted (level)
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              start,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam longint unsigned   MAX_WORDS = 64'd1 << ADDR_W;

  loader_state_e state_q, state_d;

  logic              accept;
  logic              lastByteOfWord;
  logic              lastWord;
  logic              tooLong;
  logic              csumOk;
  logic [LEN_W-1:0]  lenFull;

  logic [7:0]        lenLo_q;
  logic [LEN_W-1:0]  wordsLeft_q;
  logic [BCNT_W-1:0] byteCnt_q;
  logic [WORD_W-9:0] partial_q;
  logic [ADDR_W-1:0] nextAddr_q;

  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [WORD_W-1:0] imem_wdata_q;
  logic              startArm_q;
  logic              start_q;

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  // A byte moves only when the producer offers it and we are in a
  // stream-consuming state; everything below keys off this handshake.
  assign accept         = in_valid && in_ready;
  assign lastByteOfWord = (byteCnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  assign lastWord       = (wordsLeft_q == LEN_W'(1));

  // The full word count is only meaningful in the cycle the high length
  // byte is accepted, so it is built from the live byte and the stored low
  // byte. A frame larger than the memory is refused outright.
  assign lenFull = {in_data, lenLo_q};
  assign tooLong = (64'(lenFull) > MAX_WORDS);

  // The running sum already includes every length and payload byte by the
  // time the checksum byte arrives, so the comparison is a plain equality.
`ifdef IMEM_LOADER_CSUM_EN
  assign csumOk = (in_data == csum_q);
`else
  assign csumOk = 1'b1;
`endif

  // State register: reset wins over any request or stream activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. IDLE is only a one-cycle landing spot after reset;
  // load_req is honoured solely in the two terminal states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = LEN0;
      end
      LEN0: begin
        if (accept) begin
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          if (tooLong) begin
            state_d = ERR;
          end else if (lenFull == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept && lastByteOfWord && lastWord) begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = csumOk ? DONE : ERR;
        end
      end
      DONE, ERR: begin
        if (load_req) begin
          state_d = LEN0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Level outputs are pure functions of the current state, so done and the
  // release of core_reset coincide with entry into DONE.
  always_comb begin
    in_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state_q)
      LEN0, LEN1, DATA, CSUM: begin
        in_ready = 1'b1;
      end
      DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      ERR: begin
        error = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: byte assembly, counters, checksum and the registered memory
  // write. Partial words live in partial_q and only advance on an accepted
  // byte, so stalls of any length leave them untouched. The write strobe is
  // registered, which places it exactly one cycle after the fourth byte.
  // start is armed on the cycle DONE is entered and fires one cycle later,
  // unless a restart has already moved the FSM out of DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      lenLo_q      <= '0;
      wordsLeft_q  <= '0;
      byteCnt_q    <= '0;
      partial_q    <= '0;
      nextAddr_q   <= BASE;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE;
      imem_wdata_q <= '0;
      startArm_q   <= 1'b0;
      start_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we_q  <= 1'b0;
      startArm_q <= (state_q != DONE) && (state_d == DONE);
      start_q    <= startArm_q && (state_d == DONE);
      if (accept) begin
        case (state_q)
          LEN0: begin
            lenLo_q <= in_data;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q  <= in_data;
`endif
          end
          LEN1: begin
            wordsLeft_q <= lenFull;
            byteCnt_q   <= '0;
            nextAddr_q  <= BASE;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q      <= csum_q + in_data;
`endif
          end
          DATA: begin
            byteCnt_q <= byteCnt_q + BCNT_W'(1);
            partial_q <= {in_data, partial_q[WORD_W-9:8]};
`ifdef IMEM_LOADER_CSUM_EN
            csum_q    <= csum_q + in_data;
`endif
            if (lastByteOfWord) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= nextAddr_q;
              imem_wdata_q <= {in_data, partial_q};
              nextAddr_q   <= nextAddr_q + ADDR_W'(1);
              wordsLeft_q  <= wordsLeft_q - LEN_W'(1);
            end
          end
          default: begin
            byteCnt_q <= byteCnt_q;
          end
        endcase
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign start      = start_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader (default parameters ADDR_W=8,
//   BASE_ADDR=0). Frames are built from word lists; the expected memory
//   writes are queued as each completing byte is offered, and a monitor
//   process pops them whenever the DUT strobes imem_we. Honours
//   IMEM_LOADER_CSUM_EN for the expected outcome of bad-checksum frames.
// ---------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int BASE   = 0;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              load_req;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              start;
  logic              done;
  logic              error;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                due;
  } wr_t;

  wr_t         expQ[$];
  wr_t         mon;
  logic [31:0] curWords[$];
  int          checks     = 0;
  int          errors     = 0;
  int          cycleCount = 0;
  int          writeCount = 0;
  int          startCount = 0;
  int          doneRun    = 0;

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .start     (start),
    .done      (done),
    .error     (error)
  );

  // Free-running clock and cycle counter used to timestamp expected writes
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Safety net so the run always ends even if the DUT wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cycleCount);
    end
  endtask

  // Monitor: pops the scoreboard on every write, flags writes that arrive
  // late or never, and checks the level/pulse relationships every cycle.
  always @(negedge clk) begin
    if (done) doneRun++;
    else doneRun = 0;
    if (start) startCount++;
    if (start || doneRun == 2) checkOutput("start timing", start, doneRun == 2);
    checkOutput("core_reset vs done", core_reset, !done);
    if (imem_we) begin
      writeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected write", 1, 0);
      end else begin
        mon = expQ.pop_front();
        checkOutput("write addr", imem_addr, mon.addr);
        checkOutput("write data", imem_wdata, mon.data);
        checkOutput("write cycle", cycleCount, mon.due);
      end
    end else if (expQ.size() > 0 && expQ[0].due <= cycleCount) begin
      checkOutput("missed write", 0, 1);
      void'(expQ.pop_front());
    end
  end

  // Offer one byte (called and returning at a negedge). mode 0: back to
  // back, 1: valid low for a cycle before every byte, 2: random gaps.
  // When the byte completes a word, the expected write is queued for the
  // cycle after its acceptance.
  task automatic sendByte(input logic [7:0] b, input int mode, input bit noise,
                          input bit pushW, input int wordIdx, input logic [31:0] word);
    int gaps;
    int budget;
    wr_t e;
    gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gaps) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    if (noise) load_req = ($urandom_range(0, 3) == 0);
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checkOutput("in_ready timeout", 0, 1);
      in_valid = 1'b0;
      load_req = 1'b0;
      return;
    end
    if (pushW) begin
      e.addr = ADDR_W'((BASE + wordIdx) % DEPTH);
      e.data = word;
      e.due  = cycleCount + 1;
      expQ.push_back(e);
    end
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " in_ready"}, in_ready, 0);
    checkOutput({tag, " imem_we"}, imem_we, 0);
    checkOutput({tag, " imem_addr"}, imem_addr, BASE);
    checkOutput({tag, " imem_wdata"}, imem_wdata, 0);
    checkOutput({tag, " core_reset"}, core_reset, 1);
    checkOutput({tag, " start"}, start, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " error"}, error, 0);
  endtask

  // Send a whole frame of n words from curWords, check the outcome against
  // the framing rules, then restart the loader with load_req.
  task automatic applyStimulus(input int n, input int csumDelta, input int mode,
                               input bit noise);
    int          sum;
    bit          expDone;
    int          startsBefore;
    logic [7:0]  b;
    sendByte(8'(n & 255), mode, noise, 1'b0, 0, 0);
    sendByte(8'((n >> 8) & 255), mode, noise, 1'b0, 0, 0);
    if (n > DEPTH) begin
      expDone = 1'b0;
    end else begin
      sum = (n & 255) + ((n >> 8) & 255);
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < 4; j++) begin
          b = 8'((curWords[k] >> (8 * j)) & 32'hFF);
          sum += int'(b);
          sendByte(b, mode, noise, j == 3, k, curWords[k]);
        end
      end
      sendByte(8'((sum + csumDelta) & 255), mode, noise, 1'b0, 0, 0);
      expDone = !CSUM_EN || ((csumDelta & 255) == 0);
    end
    in_valid = 1'b0;
    checkOutput("outcome done", done, expDone);
    checkOutput("outcome error", error, !expDone);
    checkOutput("outcome core_reset", core_reset, !expDone);
    checkOutput("outcome in_ready", in_ready, 0);
    startsBefore = startCount;
    repeat (2) @(negedge clk);
    checkOutput("start pulses", startCount - startsBefore, expDone ? 1 : 0);
    checkOutput("pending writes", expQ.size(), 0);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checkOutput("restart done", done, 0);
    checkOutput("restart error", error, 0);
    checkOutput("restart core_reset", core_reset, 1);
    checkOutput("restart in_ready", in_ready, 1);
  endtask

  initial begin
    int writesBefore;
    int n;
    reset    = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle to len0 in_ready", in_ready, 1);

    $display("[TB] two-word frame, back to back");
    curWords = '{32'h0000_0013, 32'h0010_0093};
    applyStimulus(2, 0, 0, 1'b0);

    $display("[TB] same frame, in_valid toggling");
    applyStimulus(2, 0, 1, 1'b0);

    $display("[TB] empty frame");
    applyStimulus(0, 0, 0, 1'b0);

    $display("[TB] oversize frame N=0x0101");
    applyStimulus(257, 0, 0, 1'b0);

    $display("[TB] checksum off by one, then a good frame");
    applyStimulus(2, 1, 0, 1'b0);
    applyStimulus(2, 0, 2, 1'b1);

    $display("[TB] full-depth frame N=256");
    curWords = {};
    for (int k = 0; k < DEPTH; k++) curWords.push_back($urandom);
    applyStimulus(DEPTH, 0, 0, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(1, 6));
      curWords = {};
      for (int k = 0; k < n; k++) curWords.push_back($urandom);
      applyStimulus(n, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 255)) : 0,
                    int'($urandom_range(0, 2)), 1'b1);
    end

    $display("[TB] reset after five payload bytes");
    curWords = '{32'hDEAD_BEEF, 32'h0102_0304};
    writesBefore = writeCount;
    sendByte(8'h02, 0, 1'b0, 1'b0, 0, 0);
    sendByte(8'h00, 0, 1'b0, 1'b0, 0, 0);
    for (int j = 0; j < 4; j++)
      sendByte(8'((curWords[0] >> (8 * j)) & 32'hFF), 0, 1'b0, j == 3, 0, curWords[0]);
    sendByte(8'(curWords[1] & 32'hFF), 0, 1'b0, 1'b0, 0, 0);
    reset    = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    checkResetOutputs("mid-load reset");
    checkOutput("writes before reset", writeCount - writesBefore, 1);
    reset    = 1'b0;
    load_req = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post-reset in_ready", in_ready, 1);
    checkOutput("post-reset writes", writeCount - writesBefore, 1);

    $display("[TB] recovery frame");
    curWords = '{32'hCAFE_F00D};
    applyStimulus(1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
